net_bus_rx_port: RTL

Receive-side port for the NetBus broadcast fabric: one instance sits on each fan-out leg of the transmit broadcaster, consuming WDATA/WVALID and driving WREADY back into the broadcaster's OR-ed READY. It accepts only packets addressed to its node (or to the broadcast ID), tracks packet boundaries with a small state machine, and buffers accepted flits in a first-word-fall-through FIFO toward the local consumer. Non-addressed packets are never acknowledged by this port.

---
 rtl/net_bus_rx_port.sv | 136 +++++++++++++
 1 files changed

// File: rtl/net_bus_rx_port.sv
// net_bus_rx_port: NetBus broadcast-leg receiver. Accepts packets addressed to
// NODE_ID, tracks packet framing with a two-state FSM, and buffers accepted
// flits in a first-word-fall-through FIFO toward the local consumer.
// Optional feature macro: NETBUS_RX_BCAST_EN (DEST 6'h3F accepted as broadcast).
module net_bus_rx_port #(
  parameter  int unsigned DATA_WIDTH = 4,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned W          = DATA_WIDTH * 9 + 14
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic [5:0]   NODE_ID,
  input  logic [W-1:0] WDATA,
  input  logic         WVALID,
  output logic         WREADY,
  output logic [W-1:0] ODATA,
  output logic         OVALID,
  input  logic         OREADY,
  output logic         ERR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_wready;
  logic           w_err_set;
  logic           r_err;
  logic [W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_sop;
  logic           w_eop;
  logic [5:0]     w_dest;
  logic           w_match;

  // Header field extraction from the bus flit.
  assign w_sop  = WDATA[W-1];
  assign w_eop  = WDATA[W-2];
  assign w_dest = WDATA[W-3:W-8];

`ifdef NETBUS_RX_BCAST_EN
  assign w_match = (w_dest == NODE_ID) || (w_dest == 6'h3F);
`else
  assign w_match = (w_dest == NODE_ID);
`endif

  // FIFO status: full when pointers differ only in the wrap bit.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_push = w_wready;
  assign w_pop  = RSTN && !w_empty && OREADY;

  assign WREADY = w_wready;
  assign OVALID = !w_empty;
  assign ODATA  = r_mem[r_rd_ptr[AW-1:0]];
  assign ERR    = r_err;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, combinational ready and framing-error detect.
  always_comb begin
    w_state_nxt = r_state;
    w_wready    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (RSTN && WVALID && w_sop && w_match && !w_full) begin
          w_wready    = 1'b1;
          w_state_nxt = w_eop ? IDLE : RECV;
        end
      end
      RECV: begin
        if (RSTN && WVALID && !w_full) begin
          w_wready    = 1'b1;
          w_err_set   = w_sop;
          w_state_nxt = w_eop ? IDLE : RECV;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // One-cycle error pulse following a SOP accepted mid-packet.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_set;
    end
  end

  // FIFO storage; contents are don't-care until OVALID, so no reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= WDATA;
    end
  end

  // FIFO read/write pointers with wrap bit.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule
